bus_rr_matrix: RTL and testbench
================================

Name: bus_rr_matrix

Overview:
- Parametrised multi-master, multi-slave shared bus. Successor to the two-slave, single-master bus.
- Contains a round-robin arbiter with a bounded-hold (starvation) timer and a generic address decoder.
- Issues a registered read-data return with a decode-error flag.
- Sits between the CPU and DMA masters and the memory and peripheral slaves of the top level.

Parameters:
- N_MASTERS, 2, number of masters (2..8).
- N_SLAVES, 2, number of slaves (1..8).
- ADDR_W, 16, address width.
- DATA_W, 64, data width.
- REGION_W, 8, offset bits per slave. Slave index = addr >> REGION_W.
- MAX_HOLD, 16, maximum consecutive granted cycles while another master waits (≥2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  N_MASTERS  per-master bus request.
- m_wr  in  N_MASTERS  per-master write enable (1=write, 0=read).
- m_addr  in  N_MASTERS*ADDR_W  packed master addresses; master k at [k*ADDR_W +: ADDR_W].
- m_dout  in  N_MASTERS*DATA_W  packed master write data.
- m_grant  out  N_MASTERS  one-hot-or-zero grant, registered.
- m_din  out  DATA_W  read data broadcast to all masters.
- m_err  out  1  decode error for the access issued in the previous cycle.
- s_sel  out  N_SLAVES  one-hot-or-zero slave select.
- s_addr  out  ADDR_W  address to slaves.
- s_wr  out  1  write strobe to slaves.
- s_din  out  DATA_W  write data to slaves.
- s_dout  in  N_SLAVES*DATA_W  packed slave read data.

Behaviour:
- Reset (reset=1 at an edge): m_grant=0, owner invalid, state IDLE, rr pointer=0, hold counter=0, m_din=0, m_err=0.
  - Outputs are combinational from grant, so s_sel=0, s_addr=0, s_wr=0, s_din=0.
  - Reset mid-transfer drops the grant at that edge; no partial state survives.
- Arbiter FSM, states IDLE and OWNED:
  - IDLE: if any m_req bit is set, grant the first requester searching from pointer p upward (mod N_MASTERS) and go to OWNED. Grant is visible one cycle after the request.
  - OWNED, owner k:
    - If m_req[k]=0, or (hold counter = MAX_HOLD-1 and another master requests): release.
    - On release, grant the next requester searching from k+1 in the same edge (no idle gap), or go to IDLE if none.
    - Pointer becomes k+1 on every release.
    - Otherwise keep the grant and increment the hold counter.
    - The hold counter counts only while another request is pending; it clears on every new grant and whenever no other master requests.
  - A forced release (timeout) while the owner still requests makes the owner wait its round-robin turn.
- Datapath, combinational from m_grant:
  - Granted master's m_addr, m_wr and m_dout drive s_addr, s_wr and s_din. All zero when no grant.
  - Decode: idx = s_addr >> REGION_W. s_sel[idx]=1 if granted and idx < N_SLAVES; otherwise s_sel all zero.
- Read return, registered:
  - Capture the previous cycle's s_sel and an unmapped flag.
  - m_din = s_dout of the registered selected slave, else 0.
  - m_err = 1 for one cycle if the previous cycle was a granted access to an unmapped address. m_err applies to writes as well.
- Width rules:
  - idx is computed on the full address with no truncation, so addresses ≥ N_SLAVES<<REGION_W are unmapped.
  - Pointer wraps N_MASTERS-1 → 0.
- Simultaneous events: multiple requests in IDLE resolve by pointer only. Release and timeout in the same cycle are treated as a single release.

Test Plan:
- Reset, then m_req=2'b01, m_addr0=0x0010, m_wr0=1, m_dout0=0xA5 → m_grant=01 on the next cycle; s_sel=01, s_addr=0x0010, s_wr=1, s_din=0xA5; m_err=0.
- Master 0 reads 0x0105 with s_dout1=0xDEAD_BEEF → s_sel=10 in grant cycle; m_din=0xDEADBEEF one cycle later; m_din=0 after the grant drops.
- Both masters request continuously from reset → grants alternate master0 for MAX_HOLD=16 cycles, then master1 for 16 cycles; no cycle with m_grant=0 between owners.
- Master 0 drops m_req after 3 cycles while master 1 requests → m_grant 01 to 10 at the same edge; pointer=1. Master 0 re-requests against master 1's release → master 0 wins.
- Granted read at 0x0200 (N_SLAVES=2) → s_sel=00, m_err=1 for exactly one cycle, m_din=0.
- Assert reset for one cycle in mid-grant → m_grant=0, m_din=0, m_err=0 next cycle. With requests held, master 0 is granted one cycle after reset deasserts.

Source files
------------

// File: rtl/bus_rr_matrix.sv
// rtl/bus_rr_matrix.sv - multi-master multi-slave bus with round-robin arbiter and decoder
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   m_req, m_wr          per-master request and write enable
//   m_addr, m_dout       packed per-master address and write data
//   m_grant              registered one-hot-or-zero grant
//   m_din, m_err         read data and decode error for the previous cycle's access
//   s_sel, s_addr, s_wr  slave select, address and write strobe (combinational from grant)
//   s_din                write data to slaves
//   s_dout               packed per-slave read data
module bus_rr_matrix #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 2,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 64,
   parameter int REGION_W  = 8,
   parameter int MAX_HOLD  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS-1:0]          m_wr,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_dout,
   output logic [N_MASTERS-1:0]          m_grant,
   output logic [DATA_W-1:0]             m_din,
   output logic                          m_err,
   output logic [N_SLAVES-1:0]           s_sel,
   output logic [ADDR_W-1:0]             s_addr,
   output logic                          s_wr,
   output logic [DATA_W-1:0]             s_din,
   input  logic [N_SLAVES*DATA_W-1:0]    s_dout
);

   localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int HW = $clog2(MAX_HOLD);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                state_q, state_d;
   logic [MW-1:0]         owner_q, owner_d;
   logic [MW-1:0]         ptr_q, ptr_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic [N_MASTERS-1:0]  grant_q, grant_d;
   logic [N_SLAVES-1:0]   sel_q;
   logic                  err_q;

   logic [N_MASTERS-1:0]  owner_oh;
   logic                  others_req;
   logic [MW-1:0]         next_ptr;
   logic [MW:0]           pick_idle;
   logic [MW:0]           pick_rel;
   logic [ADDR_W-1:0]     idx;
   logic                  unmapped;

   // Returns {found, index} of the first requester at or after start, wrapping.
   // Iterating from the far end makes the closest requester the last write.
   function automatic logic [MW:0] pick(input logic [N_MASTERS-1:0] req,
                                        input logic [MW-1:0] start);
      logic [MW:0] r;
      int          c;
      r = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         c = (int'(start) + i) % N_MASTERS;
         if (req[c]) r = {1'b1, MW'(c)};
      end
      return r;
   endfunction

   assign owner_oh   = N_MASTERS'(1) << owner_q;
   assign others_req = |(m_req & ~owner_oh);
   assign next_ptr   = MW'((int'(owner_q) + 1) % N_MASTERS);
   assign pick_idle  = pick(m_req, ptr_q);
   assign pick_rel   = pick(m_req, next_ptr);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_idle[MW]) begin
               state_d = OWNED;
               owner_d = pick_idle[MW-1:0];
               grant_d = N_MASTERS'(1) << pick_idle[MW-1:0];
               hold_d  = '0;
            end
         end
         OWNED: begin
            // A voluntary drop and a timeout in the same cycle are one release.
            if (!m_req[owner_q] || (hold_q == HW'(MAX_HOLD - 1) && others_req)) begin
               ptr_d  = next_ptr;
               hold_d = '0;
               // Forced release: others are requesting, so the search from
               // owner+1 reaches them before wrapping back to the owner.
               if (pick_rel[MW]) begin
                  owner_d = pick_rel[MW-1:0];
                  grant_d = N_MASTERS'(1) << pick_rel[MW-1:0];
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else begin
               hold_d = others_req ? hold_q + HW'(1) : '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         sel_q   <= s_sel;
         err_q   <= unmapped;
      end
   end

   assign m_grant = grant_q;

   // Granted master's request fields, zero when nothing is granted.
   always_comb begin
      s_addr = '0;
      s_wr   = 1'b0;
      s_din  = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (grant_q[k]) begin
            s_addr = m_addr[k*ADDR_W +: ADDR_W];
            s_wr   = m_wr[k];
            s_din  = m_dout[k*DATA_W +: DATA_W];
         end
      end
   end

   // Full-width index, so any address beyond the last region is unmapped.
   assign idx = s_addr >> REGION_W;

   always_comb begin
      s_sel = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         s_sel[j] = (|grant_q) && (idx == ADDR_W'(j));
      end
   end

   assign unmapped = (|grant_q) && !(|s_sel);

   // Slaves answer in the cycle after their select, so the mux uses the
   // captured select rather than the live one.
   always_comb begin
      m_din = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         if (sel_q[j]) m_din = s_dout[j*DATA_W +: DATA_W];
      end
   end

   assign m_err = err_q;

endmodule

// File: tb/tb_bus_rr_matrix.sv
// tb/tb_bus_rr_matrix.sv - directed self-checking bench for bus_rr_matrix
module tb_bus_rr_matrix;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   m_req;
   logic [1:0]   m_wr;
   logic [31:0]  m_addr;
   logic [127:0] m_dout;
   logic [1:0]   m_grant;
   logic [63:0]  m_din;
   logic         m_err;
   logic [1:0]   s_sel;
   logic [15:0]  s_addr;
   logic         s_wr;
   logic [63:0]  s_din;
   logic [127:0] s_dout;

   int checks = 0;
   int errors = 0;

   bus_rr_matrix dut (
      .clk     (clk),
      .reset   (reset),
      .m_req   (m_req),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_dout  (m_dout),
      .m_grant (m_grant),
      .m_din   (m_din),
      .m_err   (m_err),
      .s_sel   (s_sel),
      .s_addr  (s_addr),
      .s_wr    (s_wr),
      .s_din   (s_din),
      .s_dout  (s_dout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset  = 1'b1;
      m_req  = 2'b00;
      m_wr   = 2'b00;
      m_addr = '0;
      m_dout = '0;
      s_dout = {64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_1111};
      step();
      step();
      check("rst_grant", 64'(m_grant), 64'h0);
      check("rst_din",   m_din,        64'h0);
      check("rst_err",   64'(m_err),   64'h0);
      check("rst_sel",   64'(s_sel),   64'h0);
      check("rst_saddr", 64'(s_addr),  64'h0);
      check("rst_swr",   64'(s_wr),    64'h0);
      check("rst_sdin",  s_din,        64'h0);
      reset = 1'b0;

      // write from master 0 to slave 0
      m_req  = 2'b01;
      m_wr   = 2'b01;
      m_addr = {16'h0000, 16'h0010};
      m_dout = {64'h0, 64'h0000_0000_0000_00A5};
      #1;
      check("grant_not_yet", 64'(m_grant), 64'h0);
      step();
      check("wr_grant", 64'(m_grant), 64'h1);
      check("wr_sel",   64'(s_sel),   64'h1);
      check("wr_saddr", 64'(s_addr),  64'h0010);
      check("wr_swr",   64'(s_wr),    64'h1);
      check("wr_sdin",  s_din,        64'hA5);
      check("wr_err",   64'(m_err),   64'h0);

      // read from slave 1 while still owning the bus
      m_wr   = 2'b00;
      m_addr = {16'h0000, 16'h0105};
      #1;
      check("rd_sel", 64'(s_sel), 64'h2);
      check("rd_swr", 64'(s_wr),  64'h0);
      step();
      check("rd_din",   m_din,        64'hDEAD_BEEF);
      check("rd_err",   64'(m_err),   64'h0);
      check("rd_grant", 64'(m_grant), 64'h1);
      m_req = 2'b00;
      step();
      check("rd_drop_grant", 64'(m_grant), 64'h0);
      check("rd_drop_din",   m_din,        64'hDEAD_BEEF);
      step();
      check("rd_din_zero", m_din, 64'h0);

      // unmapped read at 0x0200
      m_addr = {16'h0000, 16'h0200};
      m_req  = 2'b01;
      step();
      check("um_grant", 64'(m_grant), 64'h1);
      check("um_sel",   64'(s_sel),   64'h0);
      check("um_saddr", 64'(s_addr),  64'h0200);
      check("um_err0",  64'(m_err),   64'h0);
      m_req = 2'b00;
      step();
      check("um_err1",  64'(m_err),   64'h1);
      check("um_din",   m_din,        64'h0);
      check("um_grant0", 64'(m_grant), 64'h0);
      step();
      check("um_err_clr", 64'(m_err), 64'h0);

      // both masters request continuously from reset: 16/16 alternation
      reset  = 1'b1;
      m_req  = 2'b11;
      m_addr = {16'h0010, 16'h0010};
      step();
      check("rr_rst_grant", 64'(m_grant), 64'h0);
      reset = 1'b0;
      step();
      check("rr_m0_first", 64'(m_grant), 64'h1);
      for (int i = 1; i < 16; i++) begin
         step();
         check($sformatf("rr_m0_%0d", i), 64'(m_grant), 64'h1);
      end
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("rr_m1_%0d", i), 64'(m_grant), 64'h2);
      end
      step();
      check("rr_m0_again", 64'(m_grant), 64'h1);

      // master 0 drops after 3 granted cycles while master 1 waits
      step();
      check("drop_m0_2", 64'(m_grant), 64'h1);
      step();
      check("drop_m0_3", 64'(m_grant), 64'h1);
      m_req = 2'b10;
      step();
      check("drop_to_m1", 64'(m_grant), 64'h2);
      m_req = 2'b01;
      step();
      check("m1_rel_to_m0", 64'(m_grant), 64'h1);

      // pointer after master 0 releases to idle is 1: tie goes to master 1
      m_req = 2'b00;
      step();
      check("idle_gap", 64'(m_grant), 64'h0);
      m_req  = 2'b11;
      m_addr = {16'h0105, 16'h0010};
      step();
      check("ptr_tie_m1", 64'(m_grant), 64'h2);
      step();
      check("pre_rst_din", m_din, 64'hDEAD_BEEF);

      // reset mid-grant
      reset = 1'b1;
      step();
      check("mid_rst_grant", 64'(m_grant), 64'h0);
      check("mid_rst_din",   m_din,        64'h0);
      check("mid_rst_err",   64'(m_err),   64'h0);
      check("mid_rst_sel",   64'(s_sel),   64'h0);
      reset = 1'b0;
      step();
      check("post_rst_m0", 64'(m_grant), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
